// File: rtl/alu_mdu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder and the multiply/divide sequencer.
// Holds the ALU select codes, aluop codes, M-extension funct3 codes, FSM state type
// and the operand signedness helpers used by both decode and sign correction.
package alu_pkg;

   typedef logic [3:0] alusel_t;

   localparam alusel_t ALUSEL_AND    = 4'b0000;
   localparam alusel_t ALUSEL_OR     = 4'b0001;
   localparam alusel_t ALUSEL_ADD    = 4'b0010;
   localparam alusel_t ALUSEL_XOR    = 4'b0011;
   localparam alusel_t ALUSEL_SUB    = 4'b0100;
   localparam alusel_t ALUSEL_SLL    = 4'b0101;
   localparam alusel_t ALUSEL_SRL    = 4'b0110;
   localparam alusel_t ALUSEL_SRA    = 4'b0111;
   localparam alusel_t ALUSEL_SLT    = 4'b1000;
   localparam alusel_t ALUSEL_SLTU   = 4'b1001;
   localparam alusel_t ALUSEL_BRANCH = 4'b1010;

   localparam logic [1:0] ALUOP_MEM    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_ARITH  = 2'b10;

   localparam logic [2:0] FUNCT3_MUL    = 3'b000;
   localparam logic [2:0] FUNCT3_MULH   = 3'b001;
   localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
   localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
   localparam logic [2:0] FUNCT3_DIV    = 3'b100;
   localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
   localparam logic [2:0] FUNCT3_REM    = 3'b110;
   localparam logic [2:0] FUNCT3_REMU   = 3'b111;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;

   // MUL is treated as unsigned: its low half is identical either way.
   function automatic logic a_is_signed(input logic [2:0] f3);
      return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU) ||
             (f3 == FUNCT3_DIV)  || (f3 == FUNCT3_REM);
   endfunction

   function automatic logic b_is_signed(input logic [2:0] f3);
      return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
   endfunction

endpackage

// File: rtl/alu_mdu_ctrl_if.sv
// Bundle between main control / operand fetch and the ALU control + M-op sequencer.
// master: control side drives decode fields, operands and kill; slave: this block
// returns alusel, the writeback select, the M-op result/valid pulse and stall.
interface alu_mdu_ctrl_if #(parameter int XLEN = 32);
   import alu_pkg::*;

   logic [1:0]      aluop;
   logic [2:0]      funct3;
   logic            funct7_5;
   logic            funct7_0;
   logic            is_rtype;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            kill;
   alusel_t         alusel;
   logic            mdu_sel;
   logic [XLEN-1:0] mdu_result;
   logic            mdu_valid;
   logic            stall;

   modport master (
      output aluop, funct3, funct7_5, funct7_0, is_rtype, op_a, op_b, kill,
      input  alusel, mdu_sel, mdu_result, mdu_valid, stall
   );

   modport slave (
      input  aluop, funct3, funct7_5, funct7_0, is_rtype, op_a, op_b, kill,
      output alusel, mdu_sel, mdu_result, mdu_valid, stall
   );
endinterface

// File: rtl/alu_mdu_ctrl_mdu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath on magnitudes.
// Latency: XLEN step cycles after start; done flags the final step, whose result is
// presented combinationally. No backpressure: the owner simply stops asserting step.
// Ports: start loads magnitudes + op kind, step advances one bit, res_hi/res_lo are
// product high/low or remainder/quotient after the current step.
module mdu_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            step,
   input  logic            is_div,
   input  logic [XLEN-1:0] mag_a,
   input  logic [XLEN-1:0] mag_b,
   output logic            done,
   output logic [XLEN-1:0] res_hi,
   output logic [XLEN-1:0] res_lo
);
   localparam int CW = $clog2(XLEN);

   // hi: partial product high half / partial remainder; lo: multiplier / dividend
   // shifting out while product low bits / quotient bits shift in; m: multiplicand
   // or divisor.
   logic [XLEN-1:0] hi, lo, m;
   logic [CW-1:0]   cnt;
   logic            div_op;

   logic [XLEN:0]   mul_sum, rem_shift, trial;
   logic [XLEN-1:0] hi_n, lo_n;

   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
      rem_shift = {hi, lo[XLEN-1]};
      trial     = rem_shift - {1'b0, m};
      hi_n      = '0;
      lo_n      = '0;
      if (div_op) begin
         // Borrow out of trial means the divisor did not fit: restore.
         if (!trial[XLEN]) begin
            hi_n = trial[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], 1'b1};
         end else begin
            hi_n = rem_shift[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_n = mul_sum[XLEN:1];
         lo_n = {mul_sum[0], lo[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi     <= '0;
         lo     <= '0;
         m      <= '0;
         cnt    <= '0;
         div_op <= 1'b0;
      end else if (start) begin
         hi     <= '0;
         lo     <= is_div ? mag_a : mag_b;
         m      <= is_div ? mag_b : mag_a;
         cnt    <= CW'(XLEN - 1);
         div_op <= is_div;
      end else if (step) begin
         hi  <= hi_n;
         lo  <= lo_n;
         cnt <= cnt - 1'b1;
      end
   end

   assign done   = step && (cnt == '0);
   assign res_hi = hi_n;
   assign res_lo = lo_n;
endmodule

// File: rtl/alu_mdu_ctrl.sv
// ALU select decoder plus RV32M sequencer (IDLE/BUSY/DONE) around mdu_iter.
// Latency: alusel combinational; M op stalls XLEN+1 cycles (1 for div-by-0/overflow),
// result + mdu_valid the cycle after. Backpressure: stall holds PC/regfile; kill aborts.
// Ports: clk, rst (sync, active high), bus (slave side of alu_mdu_ctrl_if).
// XLEN must be a power of two and at least 8.
module alu_mdu_ctrl
   import alu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input logic           clk,
   input logic           rst,
   alu_mdu_ctrl_if.slave bus
);
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_t state, state_nxt;

   logic            m_op, special, div0, ovf, latch;
   logic            sa, sb;
   logic [XLEN-1:0] special_res, mag_a, mag_b;
   logic            stall, mdu_valid, mdu_sel, iter_start, iter_step, iter_done;
   logic [XLEN-1:0] raw_hi, raw_lo, result, res_q;
   logic [2*XLEN-1:0] prod, prod_c;

   // Latched per-op control; the operand magnitudes themselves live in mdu_iter.
   logic [2:0] f3_q;
   logic       negq_q, negr_q;

   // ---- base ALU select decode ----
   always_comb begin
      bus.alusel = ALUSEL_ADD;
      case (bus.aluop)
         ALUOP_MEM:    bus.alusel = ALUSEL_ADD;
         ALUOP_BRANCH: bus.alusel = ALUSEL_BRANCH;
         ALUOP_ARITH: begin
            case (bus.funct3)
               3'b000:  bus.alusel = (bus.is_rtype && bus.funct7_5) ? ALUSEL_SUB : ALUSEL_ADD;
               3'b001:  bus.alusel = ALUSEL_SLL;
               3'b010:  bus.alusel = ALUSEL_SLT;
               3'b011:  bus.alusel = ALUSEL_SLTU;
               3'b100:  bus.alusel = ALUSEL_XOR;
               3'b101:  bus.alusel = bus.funct7_5 ? ALUSEL_SRA : ALUSEL_SRL;
               3'b110:  bus.alusel = ALUSEL_OR;
               default: bus.alusel = ALUSEL_AND;
            endcase
         end
         default:      bus.alusel = ALUSEL_ADD;
      endcase
   end

   // ---- M-op detection and fast-path special cases ----
   assign m_op = ENABLE_M && (bus.aluop == ALUOP_ARITH) && bus.is_rtype && bus.funct7_0;
   assign sa   = a_is_signed(bus.funct3) && bus.op_a[XLEN-1];
   assign sb   = b_is_signed(bus.funct3) && bus.op_b[XLEN-1];
   assign mag_a = sa ? -bus.op_a : bus.op_a;
   assign mag_b = sb ? -bus.op_b : bus.op_b;

   // funct3[2] selects divide; funct3[0]==0 among divides is the signed pair DIV/REM.
   assign div0 = bus.funct3[2] && (bus.op_b == '0);
   assign ovf  = bus.funct3[2] && !bus.funct3[0] && (bus.op_a == MIN) && (bus.op_b == '1);
   assign special = div0 || ovf;

   always_comb begin
      if (div0) special_res = bus.funct3[1] ? bus.op_a : '1;
      else      special_res = bus.funct3[1] ? '0 : MIN;
   end

   // ---- FSM: state register ----
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (m_op) state_nxt = special ? DONE : BUSY;
         BUSY:    if (iter_done) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.kill) state_nxt = IDLE;
   end

   // ---- FSM: outputs (kill and reset silence everything in the same cycle) ----
   always_comb begin
      stall      = 1'b0;
      mdu_valid  = 1'b0;
      mdu_sel    = 1'b0;
      iter_start = 1'b0;
      iter_step  = 1'b0;
      if (!rst && !bus.kill) begin
         case (state)
            IDLE: begin
               stall      = m_op;
               iter_start = m_op && !special;
            end
            BUSY: begin
               stall     = 1'b1;
               iter_step = 1'b1;
            end
            DONE: begin
               mdu_valid = 1'b1;
               mdu_sel   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign latch = (state == IDLE) && stall;

   mdu_iter #(.XLEN(XLEN)) u_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (iter_start),
      .step   (iter_step),
      .is_div (bus.funct3[2]),
      .mag_a  (mag_a),
      .mag_b  (mag_b),
      .done   (iter_done),
      .res_hi (raw_hi),
      .res_lo (raw_lo)
   );

   // ---- sign correction of the final step's raw result ----
   always_comb begin
      prod   = {raw_hi, raw_lo};
      prod_c = negq_q ? -prod : prod;
      case (f3_q)
         FUNCT3_MUL:                              result = prod_c[XLEN-1:0];
         FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: result = prod_c[2*XLEN-1:XLEN];
         FUNCT3_DIV, FUNCT3_DIVU:                 result = negq_q ? -raw_lo : raw_lo;
         default:                                 result = negr_q ? -raw_hi : raw_hi;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         f3_q   <= '0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
         res_q  <= '0;
      end else begin
         if (latch) begin
            f3_q   <= bus.funct3;
            negq_q <= sa ^ sb;
            negr_q <= sa;
         end
         if (latch && special) res_q <= special_res;
         else if (iter_done)   res_q <= result;
      end
   end

   assign bus.stall      = stall;
   assign bus.mdu_valid  = mdu_valid;
   assign bus.mdu_sel    = mdu_sel;
   assign bus.mdu_result = res_q;
endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Directed bench for alu_mdu_ctrl: decode table, M-op timing, special cases,
// kill/reset aborts and back-to-back ops; M results go through a scoreboard queue.
module tb_alu_mdu_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   alu_mdu_ctrl_if #(.XLEN(32)) bus ();

   alu_mdu_ctrl #(.XLEN(32), .ENABLE_M(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every mdu_valid pulse must match the oldest expected result.
   always begin
      @(negedge clk);
      #2;
      if (bus.mdu_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("valid_without_issue", 32'(bus.mdu_valid), 32'd0);
         end else begin
            chk("mdu_result", bus.mdu_result, exp_q.pop_front());
            chk("mdu_sel_on_valid", 32'(bus.mdu_sel), 32'd1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      bus.aluop    = 2'b00;
      bus.funct7_0 = 1'b0;
      bus.funct7_5 = 1'b0;
      bus.is_rtype = 1'b0;
      bus.op_a     = $urandom;
      bus.op_b     = $urandom;
   endtask

   task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      bus.aluop    = 2'b10;
      bus.is_rtype = 1'b1;
      bus.funct7_0 = 1'b1;
      bus.funct7_5 = 1'b0;
      bus.funct3   = f3;
      bus.op_a     = a;
      bus.op_b     = b;
   endtask

   task automatic dec(input string tag, input logic [1:0] op, input logic [2:0] f3,
                      input logic f75, input logic rt, input logic [3:0] exp);
      @(negedge clk);
      bus.aluop = op; bus.funct3 = f3; bus.funct7_5 = f75; bus.is_rtype = rt;
      bus.funct7_0 = 1'b0;
      #1;
      chk({tag, "_alusel"}, 32'(bus.alusel), 32'(exp));
      chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
   endtask

   // Issue one M op, count stall cycles until the retire cycle, then expect mdu_valid.
   task automatic run_m(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
      int n;
      @(negedge clk);
      drive_m(f3, a, b);
      exp_q.push_back(exp);
      #1;
      n = bus.stall ? 1 : 0;
      for (int i = 0; i < 100 && bus.stall; i++) begin
         @(negedge clk);
         idle_inputs();
         #1;
         if (bus.stall) n++;
      end
      chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
      chk({tag, "_valid"}, 32'(bus.mdu_valid), 32'd1);
   endtask

   // Start a long divide, then kill (or reset) on BUSY cycle 10.
   task automatic abort_test(input string tag, input bit use_rst);
      int seen;
      @(negedge clk);
      drive_m(3'b100, 32'd1000, 32'd3);
      #1;
      chk({tag, "_issue_stall"}, 32'(bus.stall), 32'd1);
      for (int i = 1; i < 10; i++) begin
         @(negedge clk);
         idle_inputs();
      end
      @(negedge clk);
      if (use_rst) rst = 1'b1; else bus.kill = 1'b1;
      #1;
      chk({tag, "_stall_abort_cycle"}, 32'(bus.stall), 32'd0);
      chk({tag, "_valid_abort_cycle"}, 32'(bus.mdu_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0; bus.kill = 1'b0;
      #1;
      chk({tag, "_stall_after"}, 32'(bus.stall), 32'd0);
      chk({tag, "_idle_after"}, 32'(dut.state == alu_pkg::IDLE), 32'd1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (bus.mdu_valid === 1'b1 || bus.stall === 1'b1) seen++;
      end
      chk({tag, "_no_valid"}, 32'(seen), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      bus.kill = 1'b0;
      bus.funct3 = 3'b000;
      idle_inputs();
      bus.op_a = '0; bus.op_b = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_valid", 32'(bus.mdu_valid), 32'd0);
      chk("rst_sel", 32'(bus.mdu_sel), 32'd0);
      chk("rst_result", bus.mdu_result, 32'd0);
      rst = 1'b0;

      dec("srai",  2'b10, 3'b101, 1'b1, 1'b0, 4'b0111);
      dec("srli",  2'b10, 3'b101, 1'b0, 1'b0, 4'b0110);
      dec("sub",   2'b10, 3'b000, 1'b1, 1'b1, 4'b0100);
      dec("addi",  2'b10, 3'b000, 1'b1, 1'b0, 4'b0010);
      dec("or",    2'b10, 3'b110, 1'b0, 1'b1, 4'b0001);
      dec("and",   2'b10, 3'b111, 1'b0, 1'b1, 4'b0000);
      dec("sltu",  2'b10, 3'b011, 1'b0, 1'b1, 4'b1001);
      dec("ld",    2'b00, 3'b010, 1'b0, 1'b0, 4'b0010);
      dec("br",    2'b01, 3'b000, 1'b0, 1'b0, 4'b1010);
      dec("op11",  2'b11, 3'b100, 1'b1, 1'b1, 4'b0010);

      run_m("mul",    3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run_m("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_m("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      run_m("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);
      run_m("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_m("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
      run_m("remu_z",   3'b111, 32'h0000_1234, 32'd0, 32'h0000_1234, 1);
      run_m("divu_z",   3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run_m("div_neg",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run_m("rem_neg",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run_m("divu",     3'b101, 32'd100, 32'd7, 32'd14, 33);
      run_m("remu",     3'b111, 32'd100, 32'd7, 32'd2, 33);

      // Back-to-back: second op issues in the IDLE cycle right after DONE.
      run_m("b2b_mul0", 3'b000, 32'd12345, 32'd678, 32'd8369910, 33);
      run_m("b2b_mul1", 3'b000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 33);

      abort_test("kill", 1'b0);
      abort_test("rst", 1'b1);

      // kill beats a simultaneous start.
      @(negedge clk);
      drive_m(3'b000, 32'd3, 32'd4);
      bus.kill = 1'b1;
      #1;
      chk("kill_start_stall", 32'(bus.stall), 32'd0);
      @(negedge clk);
      bus.kill = 1'b0;
      idle_inputs();
      #1;
      chk("kill_start_no_busy", 32'(bus.stall), 32'd0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
